// File: rtl/filter_env_pkg.sv
// Shared definitions for the clocked 4-phase initiator of the dual-rail filter pipeline.
package filter_env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_WAIT_LO = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SKEW        = 0;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_CNT_W       = 16;
    localparam int SKEW_W          = 4;

    // Timer must be able to hold the value TIMEOUT itself.
    function automatic int timer_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/filter_env_driver_if.sv
// Control/filter-side signal bundle of the filter environment driver.
interface filter_env_driver_if import filter_env_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             go;
    logic [CNT_W-1:0] burst_len;
    logic             actuator_i;
    logic             start_o;
    logic             sensor_o;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic             proto_err;
    logic [CNT_W-1:0] tok_count;

    modport master (
        input  go, burst_len, actuator_i,
        output start_o, sensor_o, busy, done, timeout_err, proto_err, tok_count
    );

    modport slave (
        output go, burst_len, actuator_i,
        input  start_o, sensor_o, busy, done, timeout_err, proto_err, tok_count
    );
endinterface

// File: rtl/filter_env_driver_sync_bit.sv
// Reset-to-0 flop-chain synchronizer for a single asynchronous bit.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic chain_reg [STAGES];

    always_ff @(posedge clk) begin
        if (reset) chain_reg[0] <= 1'b0;
        else       chain_reg[0] <= d;
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk) begin
            if (reset) chain_reg[gi] <= 1'b0;
            else       chain_reg[gi] <= chain_reg[gi-1];
        end
    end

    assign q = chain_reg[STAGES-1];
endmodule

// File: rtl/filter_env_driver.sv
// Clocked 4-phase return-to-zero token initiator with per-phase timeout and token counting.
module filter_env_driver import filter_env_pkg::*; #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SKEW        = DEF_SKEW,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 reset,
    filter_env_driver_if.master bus
);
    localparam int              TW        = timer_w(TIMEOUT);
    localparam logic [TW-1:0]   TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'((SKEW > 0) ? SKEW - 1 : 0);
    localparam bit              NO_SKEW   = (SKEW == 0);

    state_t              state_reg, state_next;
    logic                start_reg, start_next;
    logic                sensor_reg, sensor_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                terr_reg, terr_next;
    logic                perr_reg, perr_next;
    logic [CNT_W-1:0]    tok_reg, tok_next, tok_inc;
    logic [CNT_W-1:0]    len_reg, len_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic [SKEW_W-1:0]   skew_reg, skew_next;
    logic                act_s;
    logic                err_exit;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.actuator_i),
        .q     (act_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            start_reg  <= 1'b0;
            sensor_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            terr_reg   <= 1'b0;
            perr_reg   <= 1'b0;
            tok_reg    <= '0;
            len_reg    <= '0;
            timer_reg  <= '0;
            skew_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            start_reg  <= start_next;
            sensor_reg <= sensor_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            terr_reg   <= terr_next;
            perr_reg   <= perr_next;
            tok_reg    <= tok_next;
            len_reg    <= len_next;
            timer_reg  <= timer_next;
            skew_reg   <= skew_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_next  = start_reg;
        sensor_next = sensor_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        terr_next   = terr_reg;
        perr_next   = perr_reg;
        tok_next    = tok_reg;
        len_next    = len_reg;
        timer_next  = timer_reg;
        skew_next   = skew_reg;
        tok_inc     = tok_reg + 1'b1;
        err_exit    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.go) begin
                    if (act_s) begin
                        // Filter not back at zero: refuse to start a token.
                        perr_next = 1'b1;
                        done_next = 1'b1;
                    end else if (bus.burst_len == '0) begin
                        done_next = 1'b1;
                        terr_next = 1'b0;
                        perr_next = 1'b0;
                        tok_next  = '0;
                    end else begin
                        len_next    = bus.burst_len;
                        tok_next    = '0;
                        terr_next   = 1'b0;
                        perr_next   = 1'b0;
                        busy_next   = 1'b1;
                        start_next  = 1'b1;
                        skew_next   = '0;
                        timer_next  = '0;
                        sensor_next = NO_SKEW;
                        state_next  = NO_SKEW ? ST_WAIT_HI : ST_RISE;
                    end
                end
            end
            ST_RISE: begin
                if (skew_reg == SKEW_LAST) begin
                    sensor_next = 1'b1;
                    timer_next  = '0;
                    state_next  = ST_WAIT_HI;
                end else begin
                    skew_next = skew_reg + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (act_s) begin
                    start_next = 1'b0;
                    skew_next  = '0;
                    timer_next = '0;
                    if (NO_SKEW) sensor_next = 1'b0;
                    state_next = NO_SKEW ? ST_WAIT_LO : ST_FALL;
                end else if (timer_reg == TIMEOUT_C) begin
                    err_exit = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_FALL: begin
                if (skew_reg == SKEW_LAST) begin
                    sensor_next = 1'b0;
                    timer_next  = '0;
                    state_next  = ST_WAIT_LO;
                end else begin
                    skew_next = skew_reg + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!act_s) begin
                    tok_next = tok_inc;
                    if (tok_inc == len_reg) begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        start_next = 1'b1;
                        skew_next  = '0;
                        timer_next = '0;
                        if (NO_SKEW) sensor_next = 1'b1;
                        state_next = NO_SKEW ? ST_WAIT_HI : ST_RISE;
                    end
                end else if (timer_reg == TIMEOUT_C) begin
                    err_exit = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Hang exit shared by both wait phases; tok_count is left as is.
        if (err_exit) begin
            start_next  = 1'b0;
            sensor_next = 1'b0;
            terr_next   = 1'b1;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            state_next  = ST_IDLE;
        end
    end

    assign bus.start_o     = start_reg;
    assign bus.sensor_o    = sensor_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.timeout_err = terr_reg;
    assign bus.proto_err   = perr_reg;
    assign bus.tok_count   = tok_reg;
endmodule

// File: tb/tb_filter_env_driver.sv
// Directed bench: two drivers (SKEW=0/TIMEOUT=50 and SKEW=4) each facing a 30-cycle filter model.
module tb_filter_env_driver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    filter_env_driver_if #(.CNT_W(16)) bus0 ();
    filter_env_driver_if #(.CNT_W(16)) bus1 ();

    filter_env_driver #(.SYNC_STAGES(2), .SKEW(0), .TIMEOUT(50), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    filter_env_driver #(.SYNC_STAGES(2), .SKEW(4), .TIMEOUT(255), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    // Filter model: Actuator follows Start&Sensor 30 cycles later, both directions.
    logic [29:0] dly0, dly1;
    logic stuck0, force0;
    always @(posedge clk) begin
        if (reset) begin
            dly0 <= '0;
            dly1 <= '0;
        end else begin
            dly0 <= {dly0[28:0], bus0.start_o & bus0.sensor_o};
            dly1 <= {dly1[28:0], bus1.start_o & bus1.sensor_o};
        end
    end
    assign bus0.actuator_i = force0 | (~stuck0 & dly0[29]);
    assign bus1.actuator_i = dly1[29];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] len;
        bit          stuck;
        bit          hold;
        bit          regoing;
        logic [15:0] exp_tok;
        int          exp_pulses;
        bit          exp_terr;
        bit          exp_perr;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        int  pulses;
        int  extra;
        bit  prev;
        bit  seen;
        if (v.stuck) stuck0 = 1'b1;
        if (v.hold) begin
            force0 = 1'b1;
            repeat (5) @(negedge clk);
        end
        @(negedge clk);
        bus0.burst_len = v.len;
        bus0.go = 1'b1;
        @(negedge clk);
        bus0.go = 1'b0;
        pulses = 0; prev = 1'b0; seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            if (v.regoing && i == 60) begin bus0.go = 1'b1; bus0.burst_len = 16'd7; end
            if (v.regoing && i == 61) begin bus0.go = 1'b0; bus0.burst_len = v.len; end
            if (bus0.start_o && !prev) pulses++;
            prev = bus0.start_o;
            if (bus0.done) seen = 1'b1;
        end
        chk($sformatf("v%0d done_seen", idx), 32'(seen), 32'd1);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus0.done) extra++;
        end
        chk($sformatf("v%0d done_once", idx), 32'(extra), 32'd0);
        chk($sformatf("v%0d tok_count", idx), 32'(bus0.tok_count), 32'(v.exp_tok));
        chk($sformatf("v%0d pulses", idx), 32'(pulses), 32'(v.exp_pulses));
        chk($sformatf("v%0d timeout_err", idx), 32'(bus0.timeout_err), 32'(v.exp_terr));
        chk($sformatf("v%0d proto_err", idx), 32'(bus0.proto_err), 32'(v.exp_perr));
        chk($sformatf("v%0d idle_outs", idx), {29'd0, bus0.busy, bus0.start_o, bus0.sensor_o}, 32'd0);
        $display("vector %0d len=%0d tok=%0d pulses=%0d terr=%0b perr=%0b", idx, v.len,
                 bus0.tok_count, pulses, bus0.timeout_err, bus0.proto_err);
        stuck0 = 1'b0;
        force0 = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int  rs, rn, fs, fn, s0, s1;
        bit  seen, found;

        vecs[0] = '{16'd3, 1'b0, 1'b0, 1'b1, 16'd3, 3, 1'b0, 1'b0};
        vecs[1] = '{16'd1, 1'b0, 1'b0, 1'b0, 16'd1, 1, 1'b0, 1'b0};
        vecs[2] = '{16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 0, 1'b0, 1'b0};
        vecs[3] = '{16'd2, 1'b1, 1'b0, 1'b0, 16'd0, 1, 1'b1, 1'b0};
        vecs[4] = '{16'd4, 1'b0, 1'b0, 1'b0, 16'd4, 4, 1'b0, 1'b0};
        vecs[5] = '{16'd2, 1'b0, 1'b1, 1'b0, 16'd4, 0, 1'b0, 1'b1};
        vecs[6] = '{16'd2, 1'b0, 1'b0, 1'b0, 16'd2, 2, 1'b0, 1'b0};

        reset = 1'b1;
        stuck0 = 1'b0; force0 = 1'b0;
        bus0.go = 1'b0; bus0.burst_len = '0;
        bus1.go = 1'b0; bus1.burst_len = '0;
        repeat (5) @(negedge clk);
        chk("reset_outs0", {bus0.start_o, bus0.sensor_o, bus0.busy, bus0.done,
                            bus0.timeout_err, bus0.proto_err, bus0.tok_count}, 32'd0);
        chk("reset_outs1", {bus1.start_o, bus1.sensor_o, bus1.busy, bus1.done,
                            bus1.timeout_err, bus1.proto_err, bus1.tok_count}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // SKEW=4: sensor edges trail start edges by exactly four clocks.
        bus1.burst_len = 16'd1;
        bus1.go = 1'b1;
        @(negedge clk);
        bus1.go = 1'b0;
        rs = -1; rn = -1; fs = -1; fn = -1; seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            if (rs < 0 && bus1.start_o) rs = i;
            if (rn < 0 && bus1.sensor_o) rn = i;
            if (rs >= 0 && fs < 0 && !bus1.start_o) fs = i;
            if (rn >= 0 && fn < 0 && !bus1.sensor_o) fn = i;
            if (bus1.done) seen = 1'b1;
        end
        chk("skew_done_seen", 32'(seen), 32'd1);
        chk("skew_rise_gap", 32'(rn - rs), 32'd4);
        chk("skew_fall_gap", 32'(fn - fs), 32'd4);
        chk("skew_tok_count", 32'(bus1.tok_count), 32'd1);
        $display("skew burst: rise gap=%0d fall gap=%0d tok=%0d", rn - rs, fn - fs, bus1.tok_count);
        repeat (5) @(negedge clk);

        // Stuck filter: timeout_err appears on the 51st WAIT_HI clock.
        stuck0 = 1'b1;
        bus0.burst_len = 16'd2;
        bus0.go = 1'b1;
        @(negedge clk);
        bus0.go = 1'b0;
        s0 = -1; s1 = -1;
        for (int i = 0; i < 500 && s1 < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (s0 < 0 && bus0.start_o) s0 = i;
            if (bus0.timeout_err) s1 = i;
        end
        chk("to_latency", 32'(s1 - s0), 32'd51);
        chk("to_outs_low", {30'd0, bus0.start_o, bus0.sensor_o}, 32'd0);
        chk("to_done", 32'(bus0.done), 32'd1);
        chk("to_busy", 32'(bus0.busy), 32'd0);
        chk("to_tok_count", 32'(bus0.tok_count), 32'd0);
        $display("timeout burst: latency=%0d done=%0b tok=%0d", s1 - s0, bus0.done, bus0.tok_count);
        stuck0 = 1'b0;
        repeat (40) @(negedge clk);

        // Reset during WAIT_HI of the second token.
        bus0.burst_len = 16'd3;
        bus0.go = 1'b1;
        @(negedge clk);
        bus0.go = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (bus0.tok_count == 16'd1 && bus0.sensor_o) found = 1'b1;
        end
        chk("rst_reach_token2", 32'(found), 32'd1);
        repeat (5) @(negedge clk);
        chk("rst_busy_before", 32'(bus0.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outs_after", {bus0.start_o, bus0.sensor_o, bus0.busy, bus0.done,
                               bus0.timeout_err, bus0.proto_err, bus0.tok_count}, 32'd0);
        $display("mid-burst reset: start=%0b sensor=%0b busy=%0b tok=%0d",
                 bus0.start_o, bus0.sensor_o, bus0.busy, bus0.tok_count);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
